// File: rtl/dot_matrix_pkg.sv
// Shared types and constants for the LED dot-matrix column scanner.
// The optional DOT_MATRIX_DIM_EN build adds brightness PWM inside each column's SHOW window.
package dot_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int NCOL              = 16;
    localparam int COL_W             = 4;
    localparam int DEFAULT_CLK_DIV   = 5000;
    localparam int DEFAULT_BLANK_CYC = 16;

endpackage

// File: rtl/dot_matrix_scan_dwell_counter.sv
// Per-column dwell counter: counts 0..CLK_DIV-1 and wraps, with a clear input.
// It flags the last BLANK cycle and the last cycle of the dwell.
module scan_dwell_counter #(
    parameter int CLK_DIV   = 5000,
    parameter int BLANK_CYC = 16,
    parameter int CNT_W     = $clog2(CLK_DIV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             blank_tc,
    output logic             dwell_tc
);

    assign blank_tc = (count == CNT_W'(BLANK_CYC - 1));
    assign dwell_tc = (count == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || clr || dwell_tc) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dot_matrix_scan_ctrl.sv
// Column scan sequencer: column select, blanking output enable, and frame-aligned buffer swap.
// When DOT_MATRIX_DIM_EN is defined, a bright input shortens the lit part of each SHOW window.
module dot_matrix_scan_ctrl
    import dot_matrix_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int BLANK_CYC = DEFAULT_BLANK_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef DOT_MATRIX_DIM_EN
    input  logic [3:0]       bright,
`endif
    input  logic             swap_req,
    output logic [COL_W-1:0] col_sel,
    output logic             col_oe,
    output logic             frame_start,
    output logic             swap_ack,
    output logic             buf_sel
);

    localparam int CNT_W = $clog2(CLK_DIV);

    scan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic             blank_tc, dwell_tc, cnt_clr;
    logic [COL_W-1:0] col_sel_d;
    logic             col_oe_d, frame_start_d, swap_ack_d, buf_sel_d;
    logic             show_entry;

    scan_dwell_counter #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .count    (cnt),
        .blank_tc (blank_tc),
        .dwell_tc (dwell_tc)
    );

    assign show_entry = (state_q == BLANK) && blank_tc;

`ifdef DOT_MATRIX_DIM_EN
    localparam int SLOT = (CLK_DIV - BLANK_CYC) / NCOL;

    logic [3:0] bright_q;
    logic [3:0] bright_eff;
    int         show_idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            bright_q <= 4'd0;
        end else if (show_entry && en) begin
            bright_q <= bright;
        end
    end

    // On the entry edge the live input is the value being captured for this column.
    always_comb begin
        bright_eff = show_entry ? bright : bright_q;
        show_idx_d = int'(cnt) + 1 - BLANK_CYC;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_sel     <= '0;
            col_oe      <= 1'b0;
            frame_start <= 1'b0;
            swap_ack    <= 1'b0;
            buf_sel     <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_sel     <= col_sel_d;
            col_oe      <= col_oe_d;
            frame_start <= frame_start_d;
            swap_ack    <= swap_ack_d;
            buf_sel     <= buf_sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = BLANK;
                BLANK:   if (blank_tc) state_d = SHOW;
                SHOW:    if (dwell_tc) state_d = BLANK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        col_sel_d     = col_sel;
        frame_start_d = 1'b0;
        swap_ack_d    = 1'b0;
        buf_sel_d     = buf_sel;
        cnt_clr       = (state_d == IDLE) || (state_q == IDLE);
        if (state_d == IDLE) begin
            col_sel_d = '0;
        end else if (state_q == IDLE) begin
            col_sel_d     = '0;
            frame_start_d = 1'b1;
        end else if ((state_q == SHOW) && dwell_tc) begin
            col_sel_d = col_sel + COL_W'(1);
            // Only the col 15 -> 0 wrap is a frame boundary where a swap may land.
            if (col_sel == COL_W'(NCOL - 1)) begin
                frame_start_d = 1'b1;
                if (swap_req) begin
                    swap_ack_d = 1'b1;
                    buf_sel_d  = ~buf_sel;
                end
            end
        end
`ifdef DOT_MATRIX_DIM_EN
        col_oe_d = (state_d == SHOW) && (show_idx_d < SLOT * (int'(bright_eff) + 1));
`else
        col_oe_d = (state_d == SHOW);
`endif
    end

endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Self-checking bench for dot_matrix_scan_ctrl against a time-based reference model.
// Define DOT_MATRIX_DIM_EN for both bench and RTL to exercise the brightness build.
module tb_dot_matrix_scan_ctrl;

`ifdef DOT_MATRIX_DIM_EN
    localparam int CLK_DIV = 34;
`else
    localparam int CLK_DIV = 8;
`endif
    localparam int BLANK_CYC = 2;
    localparam int NCOL      = 16;
    localparam int FRAME     = NCOL * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       swap_req = 1'b0;
    logic [3:0] col_sel;
    logic       col_oe, frame_start, swap_ack, buf_sel;
`ifdef DOT_MATRIX_DIM_EN
    localparam int SLOT = (CLK_DIV - BLANK_CYC) / NCOL;
    logic [3:0] bright = 4'd0;
    logic [3:0] m_bright = 4'd0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: time since scan start, from which everything else follows.
    bit         m_active = 0;
    int         m_t = 0;
    logic [3:0] m_col = 4'd0;
    logic       m_oe = 0, m_fs = 0, m_ack = 0, m_buf = 0;
    logic [3:0] prev_col = 4'd0;

    dot_matrix_scan_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
`ifdef DOT_MATRIX_DIM_EN
        .bright      (bright),
`endif
        .swap_req    (swap_req),
        .col_sel     (col_sel),
        .col_oe      (col_oe),
        .frame_start (frame_start),
        .swap_ack    (swap_ack),
        .buf_sel     (buf_sel)
    );

    always #5 clk = ~clk;

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int ph;
        if (rst) begin
            m_active = 0; m_t = 0; m_col = 4'd0;
            m_oe = 0; m_fs = 0; m_ack = 0; m_buf = 0;
        end else if (!en) begin
            m_active = 0; m_t = 0; m_col = 4'd0;
            m_oe = 0; m_fs = 0; m_ack = 0;
        end else begin
            if (!m_active) begin
                m_active = 1;
                m_t = 0;
            end else begin
                m_t++;
            end
            m_col = 4'((m_t / CLK_DIV) % NCOL);
            ph    = m_t % CLK_DIV;
            m_fs  = (m_t % FRAME) == 0;
            m_ack = m_fs && (m_t != 0) && swap_req;
            if (m_ack) m_buf = ~m_buf;
            m_oe  = ph >= BLANK_CYC;
`ifdef DOT_MATRIX_DIM_EN
            if (ph == BLANK_CYC) m_bright = bright;
            m_oe = m_oe && ((ph - BLANK_CYC) < SLOT * (int'(m_bright) + 1));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("col_sel", 32'(col_sel), 32'(m_col));
        check("col_oe", 32'(col_oe), 32'(m_oe));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("swap_ack", 32'(swap_ack), 32'(m_ack));
        check("buf_sel", 32'(buf_sel), 32'(m_buf));
        if (col_sel != prev_col) check("oe_at_col_change", 32'(col_oe), 32'd0);
        prev_col = col_sel;
        if (m_ack) swap_req = 1'b0;
`ifdef DOT_MATRIX_DIM_EN
        if ($urandom_range(0, 3) == 0) bright = 4'($urandom_range(0, 15));
`endif
    endtask

    initial begin
        bit found;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        en  = 1'b1;

        // Three frames; a swap request raised in column 5 must wait for the wrap.
        for (int i = 0; i < 3 * FRAME + 2; i++) begin
            if (m_active && m_t == 5 * CLK_DIV + 3) swap_req = 1'b1;
            step();
        end
        check("buf_after_first_swap", 32'(buf_sel), 32'd1);

        // Disable during SHOW of column 9, then re-enable with a pending request.
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            step();
            if (m_col == 4'd9 && m_oe) found = 1;
        end
        check("reach_col9_show", 32'(found), 32'd1);
        en = 1'b0;
        swap_req = 1'b1;
        step();
        check("disable_col_sel", 32'(col_sel), 32'd0);
        step();
        en = 1'b1;
        step();
        check("reenable_frame_start", 32'(frame_start), 32'd1);
        check("reenable_no_ack", 32'(swap_ack), 32'd0);
        for (int i = 0; i < FRAME + 4; i++) step();

        // Reset while showing column 12 with buf_sel high.
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            if (m_buf == 1'b0 && !m_ack) swap_req = 1'b1;
            step();
            if (m_buf && m_col == 4'd12 && m_oe) found = 1;
        end
        check("reach_col12_buf1", 32'(found), 32'd1);
        rst = 1'b1;
        step();
        check("rst_buf_sel", 32'(buf_sel), 32'd0);
        rst = 1'b0;
        swap_req = 1'b0;
        repeat (4) step();

        // Random traffic: swap requests, enable drops and occasional resets.
        for (int i = 0; i < 6 * FRAME; i++) begin
            if (!swap_req && $urandom_range(0, 39) == 0) swap_req = 1'b1;
            if ($urandom_range(0, 149) == 0) en = ~en;
            else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
